// File: rtl/process_scheduler.sv
// process_scheduler
//   Round-robin process slot controller for a single processor. Holds a valid
//   bit and saved PC per slot, and drives the dispatch handshake: ask the
//   processor to stop (switch_req/switch_ack), pick the next valid slot, then
//   pulse load_valid with that slot's PC and memory base.
//
//   Optional feature macro: SCHED_PREEMPT_EN
//     defined   - a 16-bit quantum counter forces a switch every QUANTUM
//                 retired instructions when another slot is waiting.
//     undefined - no counter; switches happen only on yield or proc_halt.
//
// Ports
//   CLK, reset                  clock, synchronous active-low reset
//   create_valid/slot/pc        install a process into a free slot
//   create_err                  one-cycle pulse: create hit an occupied slot
//   inst_retire, yield,         run-time events from the processor
//   proc_halt
//   switch_req / switch_ack     stop handshake; cur_pc sampled on the ack
//   cur_pc                      processor PC, valid while switch_ack=1
//   load_valid, load_pc         one-cycle dispatch pulse and the PC to load
//   process_offset              memory base of the running slot
//   cur_slot                    index of the running slot
//   idle                        no runnable process

module process_scheduler #(
    parameter int NPROC       = 4,
    parameter int QUANTUM     = 256,
    parameter int OFFSET_STEP = 1024,
    localparam int SW         = $clog2(NPROC)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          create_valid,
    input  logic [SW-1:0] create_slot,
    input  logic [31:0]   create_pc,
    output logic          create_err,
    input  logic          inst_retire,
    input  logic          yield,
    input  logic          proc_halt,
    input  logic [31:0]   cur_pc,
    output logic          switch_req,
    input  logic          switch_ack,
    output logic          load_valid,
    output logic [31:0]   load_pc,
    output logic [11:0]   process_offset,
    output logic [SW-1:0] cur_slot,
    output logic          idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_REQ,
        S_SELECT,
        S_LOAD
    } state_t;

    state_t            state, state_n;
    logic [NPROC-1:0]  valid;
    logic [31:0]       saved_pc [NPROC];

    logic              create_ok;
    logic [NPROC-1:0]  create_mask;
    logic [NPROC-1:0]  eligible;
    logic              others;
    logic              halt_now;
    logic [SW-1:0]     pick;
    logic [SW-1:0]     idx;
    logic              found;
    logic              expire;

    function automatic logic [11:0] slot_offset(input logic [SW-1:0] s);
        slot_offset = 12'(int'(s) * OFFSET_STEP);
    endfunction

    assign create_ok   = create_valid && !valid[create_slot];
    assign create_mask = create_ok ? (NPROC'(1) << create_slot) : '0;
    // A slot being created this very cycle may be chosen by SELECT.
    assign eligible    = valid | create_mask;
    assign others      = |(valid & ~(NPROC'(1) << cur_slot));
    assign halt_now    = (state == S_RUN) && proc_halt;

    // Round-robin pick starting after cur_slot. Iterating from the farthest
    // candidate down leaves the nearest eligible slot as the final winner;
    // cur_slot itself (distance NPROC, wrapping to 0) is the last resort.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NPROC; i >= 1; i--) begin
            idx = cur_slot + SW'(i);
            if (eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

`ifdef SCHED_PREEMPT_EN
    logic [15:0] q_cnt;

    assign expire = inst_retire && (q_cnt == 16'(QUANTUM - 1));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            q_cnt <= '0;
        end else if (state == S_LOAD) begin
            q_cnt <= '0;
        end else if (state == S_RUN && inst_retire) begin
            q_cnt <= expire ? 16'd0 : q_cnt + 16'd1;
        end
    end
`else
    localparam int unused_quantum = QUANTUM;
    logic unused_retire;

    assign unused_retire = inst_retire;
    assign expire        = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        idle       = 1'b0;
        switch_req = 1'b0;
        load_valid = 1'b0;
        case (state)
            S_IDLE: begin
                idle = 1'b1;
                if (create_ok) state_n = S_SELECT;
            end
            S_RUN: begin
                // halt beats yield beats quantum expiry
                if (proc_halt)                      state_n = S_SELECT;
                else if ((yield || expire) && others) state_n = S_REQ;
            end
            S_REQ: begin
                switch_req = 1'b1;
                if (switch_ack) state_n = S_SELECT;
            end
            S_SELECT: begin
                state_n = found ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                load_valid = 1'b1;
                state_n    = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state          <= S_IDLE;
            valid          <= '0;
            create_err     <= 1'b0;
            load_pc        <= '0;
            process_offset <= '0;
            cur_slot       <= '0;
            for (int k = 0; k < NPROC; k++) saved_pc[k] <= '0;
        end else begin
            state      <= state_n;
            // A create aimed at the halting slot sees it still valid, so the
            // halt wins and the create is reported as rejected.
            create_err <= create_valid && !create_ok;

            if (halt_now) valid[cur_slot] <= 1'b0;
            if (create_ok) begin
                valid[create_slot]    <= 1'b1;
                saved_pc[create_slot] <= create_pc;
            end
            if (state == S_REQ && switch_ack) saved_pc[cur_slot] <= cur_pc;

            // Registered here so the outputs are already correct during LOAD.
            if (state == S_SELECT && found) begin
                cur_slot       <= pick;
                process_offset <= slot_offset(pick);
                load_pc        <= (create_ok && create_slot == pick) ? create_pc
                                                                     : saved_pc[pick];
            end
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: a slot-table model predicts every output each
// cycle, and directed scenarios pin key values with literal expectations.
module tb_process_scheduler;

    localparam int NPROC       = 4;
    localparam int QUANTUM     = 4;
    localparam int OFFSET_STEP = 1024;
    localparam int SW          = 2;

`ifdef SCHED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          create_valid = 1'b0;
    logic [SW-1:0] create_slot = '0;
    logic [31:0]   create_pc = '0;
    logic          create_err;
    logic          inst_retire = 1'b0;
    logic          yield = 1'b0;
    logic          proc_halt = 1'b0;
    logic [31:0]   cur_pc = '0;
    logic          switch_req;
    logic          switch_ack = 1'b0;
    logic          load_valid;
    logic [31:0]   load_pc;
    logic [11:0]   process_offset;
    logic [SW-1:0] cur_slot;
    logic          idle;

    always #5 CLK = ~CLK;

    process_scheduler #(
        .NPROC(NPROC), .QUANTUM(QUANTUM), .OFFSET_STEP(OFFSET_STEP)
    ) dut (
        .CLK(CLK), .reset(reset),
        .create_valid(create_valid), .create_slot(create_slot),
        .create_pc(create_pc), .create_err(create_err),
        .inst_retire(inst_retire), .yield(yield), .proc_halt(proc_halt),
        .cur_pc(cur_pc), .switch_req(switch_req), .switch_ack(switch_ack),
        .load_valid(load_valid), .load_pc(load_pc),
        .process_offset(process_offset), .cur_slot(cur_slot), .idle(idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: slot table plus controller phase ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_REQ = 2, M_SEL = 3, M_LOAD = 4;

    int          m_ph;
    bit          m_on = 1'b0;
    bit          m_valid [NPROC];
    logic [31:0] m_pc [NPROC];
    int          m_cur;
    logic [31:0] m_lpc;
    bit          m_err;
    int          m_ret;     // instructions retired since the last dispatch

    always @(posedge CLK) begin
        bit ok, others, expiry;
        int sel, s;
        if (!reset) begin
            m_on = 1'b1; m_ph = M_IDLE; m_cur = 0; m_lpc = '0; m_err = 1'b0; m_ret = 0;
            for (int j = 0; j < NPROC; j++) begin m_valid[j] = 1'b0; m_pc[j] = '0; end
        end else if (m_on) begin
            ok = create_valid && !m_valid[create_slot];
            m_err = create_valid && !ok;
            others = 1'b0;
            for (int j = 0; j < NPROC; j++) if (j != m_cur && m_valid[j]) others = 1'b1;
            case (m_ph)
                M_IDLE: if (ok) m_ph = M_SEL;
                M_RUN: begin
                    expiry = PREEMPT && inst_retire && ((m_ret + 1) % QUANTUM == 0);
                    if (inst_retire) m_ret++;
                    if (proc_halt) begin
                        m_valid[m_cur] = 1'b0;
                        m_ph = M_SEL;
                    end else if ((yield || expiry) && others) m_ph = M_REQ;
                end
                M_REQ: if (switch_ack) begin m_pc[m_cur] = cur_pc; m_ph = M_SEL; end
                M_SEL: begin
                    sel = -1;
                    for (int k = 1; k <= NPROC; k++) begin
                        s = (m_cur + k) % NPROC;
                        if (sel < 0 && (m_valid[s] || (ok && int'(create_slot) == s))) sel = s;
                    end
                    if (sel < 0) m_ph = M_IDLE;
                    else begin
                        m_ph  = M_LOAD;
                        m_cur = sel;
                        m_lpc = (ok && int'(create_slot) == sel) ? create_pc : m_pc[sel];
                        m_ret = 0;
                    end
                end
                M_LOAD: m_ph = M_RUN;
                default: m_ph = M_IDLE;
            endcase
            if (ok) begin m_valid[create_slot] = 1'b1; m_pc[create_slot] = create_pc; end
        end
    end

    always @(negedge CLK) begin
        if (m_on) begin
            cmp("m_idle",       idle,           32'(m_ph == M_IDLE));
            cmp("m_switch_req", switch_req,     32'(m_ph == M_REQ));
            cmp("m_load_valid", load_valid,     32'(m_ph == M_LOAD));
            cmp("m_load_pc",    load_pc,        m_lpc);
            cmp("m_cur_slot",   cur_slot,       32'(m_cur));
            cmp("m_offset",     process_offset, 32'((m_cur * OFFSET_STEP) % 4096));
            cmp("m_create_err", create_err,     32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic create(input int slot, input logic [31:0] pc);
        create_valid = 1'b1; create_slot = SW'(slot); create_pc = pc;
        tick();
        create_valid = 1'b0;
    endtask

    // which: 0 = load_valid, 1 = switch_req
    task automatic wait_for(input int which, input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i <= bound && !seen; i++) begin
            if ((which == 0 && load_valid === 1'b1) || (which == 1 && switch_req === 1'b1))
                seen = 1'b1;
            else
                tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: event not seen within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        cmp("rst_idle", idle, 1);
        cmp("rst_switch_req", switch_req, 0);
        cmp("rst_load_pc", load_pc, 0);
        cmp("rst_offset", process_offset, 0);
        reset = 1'b1;
        tick();

        // first process dispatch
        create(0, 32'h40);
        wait_for(0, 3, "first_load");
        cmp("t1_idle", idle, 0);
        cmp("t1_load_pc", load_pc, 32'h40);
        cmp("t1_offset", process_offset, 0);
        cmp("t1_slot", cur_slot, 0);
        tick();

        // two processes: quantum expiry (or yield without preemption)
        create(2, 32'h800);
        inst_retire = 1'b1; repeat (4) tick(); inst_retire = 1'b0;
        yield = 1'b1; tick(); yield = 1'b0;
        wait_for(1, 2, "t2_req");
        cmp("t2_switch_req", switch_req, 1);
        switch_ack = 1'b1; cur_pc = 32'h50; tick(); switch_ack = 1'b0;
        wait_for(0, 3, "t2_load");
        cmp("t2_load_pc", load_pc, 32'h800);
        cmp("t2_offset", process_offset, 2048);
        cmp("t2_slot", cur_slot, 2);
        tick();

        // halt slot 2; slot 0 resumes from the PC saved on the ack
        proc_halt = 1'b1; tick(); proc_halt = 1'b0;
        wait_for(0, 2, "t3_load");
        cmp("t3_saved_pc", load_pc, 32'h50);
        cmp("t3_slot", cur_slot, 0);
        tick();

        // single process: no switch on retires or yield
        inst_retire = 1'b1; repeat (10) tick(); inst_retire = 1'b0;
        cmp("t4_switch_req", switch_req, 0);
        cmp("t4_slot", cur_slot, 0);
        yield = 1'b1; tick(); yield = 1'b0;
        cmp("t4_yield_ignored", switch_req, 0);

        // slots 1 and 3, run 3, halt paths
        create(1, 32'h100);
        create(3, 32'h300);
        proc_halt = 1'b1; tick(); proc_halt = 1'b0;
        wait_for(0, 2, "t5_load1");
        cmp("t5_load_pc", load_pc, 32'h100);
        cmp("t5_slot", cur_slot, 1);
        tick();
        yield = 1'b1; tick(); yield = 1'b0;
        wait_for(1, 2, "t5_req");
        switch_ack = 1'b1; cur_pc = 32'h110; tick(); switch_ack = 1'b0;
        wait_for(0, 3, "t5_load3");
        cmp("t5_load_pc3", load_pc, 32'h300);
        cmp("t5_offset3", process_offset, 3072);
        tick();

        create(1, 32'h777);
        cmp("t6_dup_err", create_err, 1);
        tick();
        cmp("t6_dup_err_once", create_err, 0);

        proc_halt = 1'b1; tick(); proc_halt = 1'b0;
        wait_for(0, 2, "t6_load1");
        cmp("t6_pc_unchanged", load_pc, 32'h110);
        cmp("t6_slot", cur_slot, 1);
        tick();

        proc_halt = 1'b1; create_valid = 1'b1; create_slot = 1; create_pc = 32'hABC;
        tick();
        proc_halt = 1'b0; create_valid = 1'b0;
        cmp("t7_halt_create_err", create_err, 1);
        tick(); tick();
        cmp("t7_idle", idle, 1);
        cmp("t7_switch_req", switch_req, 0);
        cmp("t7_load_valid", load_valid, 0);

        // create during SELECT is eligible, then reset while awaiting ack
        create(0, 32'h40);
        create(2, 32'h800);
        wait_for(0, 2, "t8_load");
        cmp("t8_load_pc", load_pc, 32'h800);
        cmp("t8_slot", cur_slot, 2);
        tick();
        yield = 1'b1; tick(); yield = 1'b0;
        cmp("t8_switch_req", switch_req, 1);
        tick();
        cmp("t8_hold_req", switch_req, 1);
        reset = 1'b0; tick(); reset = 1'b1;
        cmp("t9_switch_req", switch_req, 0);
        cmp("t9_idle", idle, 1);
        cmp("t9_slot", cur_slot, 0);
        cmp("t9_load_pc", load_pc, 0);
        repeat (3) tick();
        cmp("t9_still_idle", idle, 1);
        create(0, 32'h123);
        cmp("t9_create_ok", create_err, 0);
        wait_for(0, 3, "t9_load");
        cmp("t9_only_new_slot", load_pc, 32'h123);
        cmp("t9_slot0", cur_slot, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
